bm_mem_arbiter: RTL
===================

Name: bm_mem_arbiter

Overview:
- Round-robin, burst-locked arbiter that shares the single-port bin memory between the Bin_Manager sub-units.
- Requester index map: 0 = read bin info, 1 = load bin, 2 = update bin, 3 = backtrack across bin.
- Sits between those units and the bin RAM.
- Routes read data back to the issuing requester through a latency-matched tag pipeline, so grants can change while reads are still in flight.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH_ADDR, 16, memory address width.
- WIDTH_DATA, 32, memory data width.
- RD_LATENCY, 2, memory read latency in cycles (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_i  in  NUM_REQ  per-requester beat request; level-held while a beat is pending.
- last_i  in  NUM_REQ  marks the final beat of a burst; qualified by req_i.
- we_i  in  NUM_REQ  beat is a write (1) or read (0).
- addr_i  in  NUM_REQ*WIDTH_ADDR  packed beat addresses; requester k uses slice k.
- wdata_i  in  NUM_REQ*WIDTH_DATA  packed write data.
- gnt_o  out  NUM_REQ  one-hot grant, held for the whole burst.
- rvalid_o  out  NUM_REQ  one-hot read-data-valid, one pulse per read beat.
- rdata_o  out  WIDTH_DATA  read data, common to all requesters; qualified by rvalid_o.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  WIDTH_ADDR  memory address.
- mem_wdata_o  out  WIDTH_DATA  memory write data.
- mem_rdata_i  in  WIDTH_DATA  memory read data, valid RD_LATENCY cycles after the read strobe.
- busy_o  out  1  high when the FSM is not IDLE or any read is in flight.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - gnt_o=0, rvalid_o=0, busy_o=0.
  - Round-robin pointer last_gnt = NUM_REQ-1, so requester 0 has top priority after reset.
  - Tag pipeline cleared.
  - Reset mid-burst discards in-flight reads; no rvalid_o may appear afterwards.
- FSM states: IDLE, BURST, SWITCH.
  - IDLE: if any req_i bit is set, choose the first set bit scanning last_gnt+1 upward with wrap-around. Register the one-hot grant into gnt_o; next state BURST. gnt_o therefore rises 1 cycle after req_i.
  - BURST: a beat is accepted in every cycle where (gnt_o & req_i)!=0.
    - Accepted beat with last_i of the granted requester set: last_gnt <= granted index; next state SWITCH.
    - Granted requester drops req_i without last_i: grant is held (stall), mem_en_o=0, no other requester is granted.
  - SWITCH: gnt_o=0 for exactly one cycle, giving a one-cycle bubble between bursts. Arbitrate as in IDLE: if a request is pending go to BURST with the new grant, else go to IDLE.
- Memory interface, combinational from the granted requester's slices:
  - mem_en_o = |(gnt_o & req_i).
  - mem_we_o = mem_en_o & we_i[g].
  - mem_addr_o = addr_i slice g; mem_wdata_o = wdata_i slice g.
  - When mem_en_o=0: mem_addr_o and mem_wdata_o are 0, mem_we_o=0.
- Tag pipeline:
  - RD_LATENCY registered stages of {valid, id}.
  - Stage 0 is loaded with {mem_en_o & ~mem_we_o, g} every cycle.
  - rvalid_o is the one-hot decode of the final stage (all zero if that stage is invalid).
  - rdata_o = mem_rdata_i passed through combinationally.
  - Read data therefore returns exactly RD_LATENCY cycles after the beat, regardless of later grant changes.
- Write beats produce no rvalid_o.
- Single-beat bursts (req and last together) are legal.
- A new burst may start while reads from the previous burst are still in the pipeline; ordering and routing are preserved by the tags.
- last_i without req_i is ignored.

Test Plan:
- Read burst: req 1 at t0, 3 beats at addr 0x10,0x11,0x12, last on the third, RD_LATENCY=2 -> gnt_o=4'b0010 from t1; mem_en_o high t1..t3 with those addresses; rvalid_o=4'b0010 at t3..t5 carrying the memory words; SWITCH at t4; IDLE at t5.
- Simultaneous req 0 and 2 (single beat each) right after reset -> gnt_o=0001 at t1, 0000 at t2, 0100 at t3.
- All four requesting continuously with single-beat bursts -> grant sequence 0,1,2,3,0, each grant separated by one zero cycle.
- Requester 2 granted, issues 1 beat, drops req for 3 cycles, then resumes with last while requester 0 is requesting throughout -> gnt_o stays 0100; mem_en_o=0 for those 3 cycles; requester 0 granted only after the SWITCH cycle.
- Write beat from requester 3 with addr 0x5, data 0xDEADBEEF -> mem_we_o=1, mem_addr_o=0x5, mem_wdata_o=0xDEADBEEF; no rvalid_o pulse.
- rst driven low mid-burst with 2 reads in flight -> gnt_o, rvalid_o and busy_o are 0 immediately (asynchronous); no rvalid_o after release; the first grant after reset goes to the lowest-index requester.

Source files
------------

// File: rtl/bm_mem_arbiter.sv
// -----------------------------------------------------------------------------
// bm_mem_arbiter
//
// Round-robin, burst-locked arbiter that shares the single-port bin memory
// between the Bin_Manager sub-units. The index map of the requesters is:
// 0 = read bin info, 1 = load bin, 2 = update bin, 3 = backtrack across bin.
//
// A grant is held for a whole burst, up to and including the beat that carries
// last_i. Each grant change is followed by a one-cycle bubble with no grant.
// Read data is routed back to the requester that issued the read by a tag
// pipeline. Its length matches the memory read latency, so the grant can move
// on while reads are still in flight.
//
// Ports:
//   clk          clock
//   rst          asynchronous reset, active low
//   req_i        per-requester beat request, level-held while a beat is pending
//   last_i       final beat of a burst (qualified by req_i)
//   we_i         beat is a write (1) or a read (0)
//   addr_i       packed beat addresses, slice k belongs to requester k
//   wdata_i      packed write data, slice k belongs to requester k
//   gnt_o        one-hot grant, held for the whole burst
//   rvalid_o     one-hot read-data-valid, one pulse per read beat
//   rdata_o      read data common to all requesters (qualified by rvalid_o)
//   mem_en_o     memory access strobe
//   mem_we_o     memory write enable
//   mem_addr_o   memory address
//   mem_wdata_o  memory write data
//   mem_rdata_i  memory read data, valid RD_LATENCY cycles after the strobe
//   busy_o       FSM not idle, or a read still in flight
// -----------------------------------------------------------------------------
module bm_mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_ADDR = 16,
    parameter int WIDTH_DATA = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            last_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0] addr_i,
    input  logic [NUM_REQ*WIDTH_DATA-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [WIDTH_DATA-1:0]         rdata_o,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [WIDTH_ADDR-1:0]         mem_addr_o,
    output logic [WIDTH_DATA-1:0]         mem_wdata_o,
    input  logic [WIDTH_DATA-1:0]         mem_rdata_i,
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // The position arithmetic needs one extra bit. The sum base + offset can
    // reach 2*(NUM_REQ-1) before it wraps.
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W:0] LAST_IDX  = (IDX_W+1)'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_SWITCH
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_d;
    logic [IDX_W-1:0]       last_gnt_q, last_gnt_d;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   beat;

    logic [2*NUM_REQ-1:0]   req_dbl;
    logic [NUM_REQ-1:0]     arb_rot;
    logic [IDX_W:0]         arb_base;
    logic [IDX_W:0]         arb_pos;
    logic                   arb_found;
    logic [IDX_W-1:0]       arb_idx;
    logic [NUM_REQ-1:0]     arb_onehot;

    logic [RD_LATENCY-1:0]             tag_vld;
    logic [RD_LATENCY-1:0][IDX_W-1:0]  tag_id;

    // -------------------------------------------------------------------------
    // Round-robin pick: the first set request at or after last_gnt+1, with
    // wrap-around. The doubled request vector is rotated so that the
    // preferred requester lands in bit 0. A fixed-priority scan then finds it.
    // -------------------------------------------------------------------------
    assign req_dbl = {req_i, req_i};

    always_comb begin
        // NOTE: every variable gets a default before any branch. An assignment
        // missing on some path would infer a latch.
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_pos   = '0;
        arb_base  = ({1'b0, last_gnt_q} == LAST_IDX) ? '0
                                                      : ({1'b0, last_gnt_q} + 1'b1);
        arb_rot   = NUM_REQ'(req_dbl >> arb_base);
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!arb_found && arb_rot[j]) begin
                arb_found = 1'b1;
                arb_pos   = arb_base + (IDX_W+1)'(j);
                if (arb_pos >= NUM_REQ_W) begin
                    arb_pos = arb_pos - NUM_REQ_W;
                end
                arb_idx = arb_pos[IDX_W-1:0];
            end
        end
    end

    assign arb_onehot = NUM_REQ'(1) << arb_idx;

    // Convert the registered one-hot grant to an index.
    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_o[k]) begin
                gnt_idx = IDX_W'(k);
            end
        end
    end

    // A beat moves in every cycle where the granted requester is asking.
    assign beat = |(gnt_o & req_i);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples values from before the clock edge.
            state_q    <= ST_IDLE;
            gnt_o      <= '0;
            last_gnt_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            gnt_o      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and next grant
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_o;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            // IDLE and SWITCH arbitrate in the same way. In SWITCH the grant
            // register already holds zero, and that zero is the bubble cycle.
            ST_IDLE, ST_SWITCH: begin
                if (arb_found) begin
                    gnt_d   = arb_onehot;
                    state_d = ST_BURST;
                end else begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                // If the requester stalls (req_i low, no last_i), the grant is
                // simply held.
                if (beat && last_i[gnt_idx]) begin
                    last_gnt_d = gnt_idx;
                    gnt_d      = '0;
                    state_d    = ST_SWITCH;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Memory port. It is driven from the granted requester's slices and is
    // forced to zero when no beat is moving.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_en_o    = beat;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (beat) begin
            mem_we_o    = we_i[gnt_idx];
            mem_addr_o  = addr_i[gnt_idx*WIDTH_ADDR +: WIDTH_ADDR];
            mem_wdata_o = wdata_i[gnt_idx*WIDTH_DATA +: WIDTH_DATA];
        end
    end

    // -------------------------------------------------------------------------
    // Tag pipeline. There is one {valid, id} stage per cycle of read latency.
    // The final stage therefore lines up with mem_rdata_i for the beat that
    // launched it, whatever the grant has done since.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: these registers are reset on purpose. They are control
            // state, not storage, and a reset during a burst must not leave a
            // stale read that would raise rvalid_o after release.
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= mem_en_o & ~mem_we_o;
            tag_id[0]  <= gnt_idx;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rvalid_o[k] = tag_vld[RD_LATENCY-1] && (tag_id[RD_LATENCY-1] == IDX_W'(k));
        end
    end

    assign rdata_o = mem_rdata_i;
    assign busy_o  = (state_q != ST_IDLE) || (|tag_vld);

endmodule
